// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: memop codes, FSM states
// and the request legality check.
package dmem_pkg;

    localparam logic [2:0] MOP_B  = 3'b000;
    localparam logic [2:0] MOP_H  = 3'b001;
    localparam logic [2:0] MOP_W  = 3'b010;
    localparam logic [2:0] MOP_BU = 3'b100;
    localparam logic [2:0] MOP_HU = 3'b101;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StWait,
        StWr,
        StResp
    } state_e;

    // Illegal memop for the access direction, or address not aligned to the access size.
    function automatic logic memop_bad(input logic we, input logic [2:0] memop,
                                       input logic [1:0] addr_lo);
        logic bad;
        case (memop)
            MOP_B:   bad = 1'b0;
            MOP_H:   bad = addr_lo[0];
            MOP_W:   bad = (addr_lo != 2'b00);
            MOP_BU:  bad = we;
            MOP_HU:  bad = we | addr_lo[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Lane steering for sub-word accesses: extracts and extends load data, and merges
// a store lane into the word read back from the SRAM.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  memop_i,
    input  logic [1:0]  byte_off_i,
    input  logic [31:0] rdata_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] store_word_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rdata_i[{byte_off_i, 3'b000} +: 8];
        half_v = byte_off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        load_data_o = rdata_i;
        case (memop_i)
            MOP_B:   load_data_o = {{24{byte_v[7]}}, byte_v};
            MOP_BU:  load_data_o = {24'h0, byte_v};
            MOP_H:   load_data_o = {{16{half_v[15]}}, half_v};
            MOP_HU:  load_data_o = {16'h0, half_v};
            default: load_data_o = rdata_i;
        endcase
    end

    always_comb begin
        store_word_o = rdata_i;
        case (memop_i)
            MOP_B: store_word_o[{byte_off_i, 3'b000} +: 8] = wdata_i[7:0];
            MOP_H: begin
                if (byte_off_i[1]) begin
                    store_word_o[31:16] = wdata_i[15:0];
                end else begin
                    store_word_o[15:0] = wdata_i[15:0];
                end
            end
            default: store_word_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: byte/half/word loads and stores against a single-port
// word SRAM, with read-modify-write for sub-word stores.
module dmem_ctrl #(
    parameter int unsigned ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_memop,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    import dmem_pkg::*;

    state_e              state_q, state_d;
    logic                we_q;
    logic [2:0]          memop_q;
    logic [1:0]          off_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic [31:0]         rdata_q;
    logic                err_q;

    logic                accept;
    logic                range_err;
    logic                req_err;
    logic [31:0]         load_data;
    logic [31:0]         store_word;

    assign accept    = (state_q == StIdle) && req_valid;
    assign range_err = |req_addr[31:ADDR_W+2];
    assign req_err   = range_err | memop_bad(req_we, req_memop, req_addr[1:0]);

    dmem_lane_align u_lane_align (
        .memop_i      (memop_q),
        .byte_off_i   (off_q),
        .rdata_i      (ram_rdata),
        .wdata_i      (wdata_q),
        .load_data_o  (load_data),
        .store_word_o (store_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (req_err) begin
                        state_d = StResp;
                    end else if (req_we && (req_memop == MOP_W)) begin
                        state_d = StWr;
                    end else begin
                        state_d = StRd;
                    end
                end
            end
            StRd:   state_d = StWait;
            StWait: state_d = we_q ? StWr : StResp;
            StWr:   state_d = StResp;
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // SRAM strobes come straight from the state so reset drops them without a clock.
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        unique case (state_q)
            StIdle: req_ready = 1'b1;
            StRd:   ram_en = 1'b1;
            StWr: begin
                ram_en = 1'b1;
                ram_we = 1'b1;
            end
            StResp: rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // wdata_q doubles as the SRAM write word: raw store data, then the merged word for RMW.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            memop_q <= MOP_B;
            off_q   <= 2'b00;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else if (accept) begin
            we_q    <= req_we;
            memop_q <= req_memop;
            off_q   <= req_addr[1:0];
            addr_q  <= req_addr[ADDR_W+1:2];
            wdata_q <= req_wdata;
            rdata_q <= 32'h0;
            err_q   <= req_err;
        end else if (state_q == StWait) begin
            if (we_q) begin
                wdata_q <= store_word;
            end else begin
                rdata_q <= load_data;
            end
        end
    end

    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed test-plan cases plus randomized
// traffic against a byte-level reference model and a behavioural SRAM.
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_memop = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        ram_en;
    logic        ram_we;
    logic [14:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = 32'h0;

    int n_vec  = 0;
    int n_fail = 0;

    logic [31:0] mem [0:32767];
    logic [31:0] ref_mem [0:32767];
    logic        bd_we = 1'b0;
    logic [14:0] bd_addr = 15'h0;
    logic [31:0] bd_data = 32'h0;
    int          en_cnt = 0;
    int          we_cnt = 0;
    logic [31:0] last_wdata = 32'h0;

    dmem_ctrl #(.ADDR_W(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_memop (req_memop),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    // SRAM with 1-cycle read latency, plus a backdoor port for preloading
    always @(posedge clk) begin
        if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end else if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= mem[ram_addr];
        end
        if (ram_en) en_cnt <= en_cnt + 1;
        if (ram_en && ram_we) begin
            we_cnt     <= we_cnt + 1;
            last_wdata <= ram_wdata;
        end
    end

    // ---------------- reference model ----------------
    function automatic int m_size(input logic [2:0] mop);
        if (mop[1:0] == 2'b00) return 1;
        if (mop[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit m_err(input bit we, input logic [2:0] mop, input logic [31:0] addr);
        bit legal;
        legal = we ? (mop inside {3'd0, 3'd1, 3'd2}) : (mop inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        return !legal || ((addr % m_size(mop)) != 0) || (addr >= 32'h0002_0000);
    endfunction

    function automatic logic [31:0] m_mask(input int size);
        return (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 32'h1);
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] word, input logic [2:0] mop,
                                           input logic [31:0] addr);
        int size;
        logic [31:0] v;
        size = m_size(mop);
        v = (word >> (8 * (addr % 4))) & m_mask(size);
        if (!mop[2] && size < 4 && v[8 * size - 1]) v = v | ~m_mask(size);
        return v;
    endfunction

    function automatic logic [31:0] m_store(input logic [31:0] word, input logic [31:0] wd,
                                            input logic [2:0] mop, input logic [31:0] addr);
        int sh;
        logic [31:0] mk;
        sh = 8 * int'(addr % 4);
        mk = m_mask(m_size(mop));
        return (word & ~(mk << sh)) | ((wd & mk) << sh);
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic bd_write(input logic [14:0] idx, input logic [31:0] data);
        @(negedge clk);
        bd_we = 1'b1; bd_addr = idx; bd_data = data;
        @(posedge clk);
        #1 bd_we = 1'b0;
    endtask

    // Issues one request and reports the response and its latency counted from the accept edge.
    task automatic do_req(input bit we, input logic [2:0] mop, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] rd, output logic er,
                          output int lat, output int en_d, output int we_d);
        bit acc;
        int en0, we0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_memop = mop; req_addr = addr; req_wdata = wd;
        acc = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (req_ready) begin acc = 1'b1; break; end
            @(negedge clk);
        end
        en0 = en_cnt; we0 = we_cnt; lat = 0;
        if (acc) begin
            @(posedge clk);
            for (int i = 1; i <= 10; i++) begin
                @(negedge clk);
                req_valid = 1'b0;
                if (rsp_valid) begin lat = i; break; end
            end
        end
        req_valid = 1'b0;
        rd = rsp_rdata; er = rsp_err; en_d = en_cnt - en0; we_d = we_cnt - we0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if ({req_ready, rsp_valid, rsp_err, ram_en, ram_we} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got rdy/vld/err/en/we=%b, need 10000",
                     {req_ready, rsp_valid, rsp_err, ram_en, ram_we});
        end
        n_vec++;
        if (rsp_rdata !== 32'h0 || ram_addr !== 15'h0 || ram_wdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h, need zeros",
                     rsp_rdata, ram_addr, ram_wdata);
        end
        bd_write(15'h40, 32'h8899_AABB);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_loads();
        logic [2:0]  mops [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        logic [31:0] adrs [5] = '{32'h101, 32'h103, 32'h102, 32'h100, 32'h100};
        logic [31:0] exps [5] = '{32'hFFFF_FFAA, 32'h0000_0088, 32'hFFFF_8899,
                                  32'h0000_AABB, 32'h8899_AABB};
        logic [31:0] rd;
        logic er;
        int lat, en_d, we_d;
        for (int i = 0; i < 5; i++) begin
            do_req(1'b0, mops[i], adrs[i], 32'h0, rd, er, lat, en_d, we_d);
            n_vec++;
            if (rd !== exps[i] || er !== 1'b0 || lat != 3 || en_d != 1 || we_d != 0) begin
                n_fail++;
                $display("FAIL load[%0d]: got data=%h err=%b lat=%0d en=%0d we=%0d, need %h 0 3 1 0",
                         i, rd, er, lat, en_d, we_d, exps[i]);
            end
        end
    endtask

    task automatic test_stores();
        logic [2:0]  mops [2] = '{3'b000, 3'b001};
        logic [31:0] adrs [2] = '{32'h102, 32'h100};
        logic [31:0] wds  [2] = '{32'h1234_5678, 32'h0000_CAFE};
        logic [31:0] exps [2] = '{32'h8878_AABB, 32'h8878_CAFE};
        logic [31:0] rd;
        logic er;
        int lat, en_d, we_d;
        for (int i = 0; i < 2; i++) begin
            do_req(1'b1, mops[i], adrs[i], wds[i], rd, er, lat, en_d, we_d);
            n_vec++;
            if (rd !== 32'h0 || er !== 1'b0 || lat != 4 || en_d != 2 || we_d != 1) begin
                n_fail++;
                $display("FAIL store[%0d]: got data=%h err=%b lat=%0d en=%0d we=%0d, need 0 0 4 2 1",
                         i, rd, er, lat, en_d, we_d);
            end
            n_vec++;
            if (last_wdata !== exps[i] || mem[15'h40] !== exps[i]) begin
                n_fail++;
                $display("FAIL store_word[%0d]: got wdata=%h mem=%h, need %h",
                         i, last_wdata, mem[15'h40], exps[i]);
            end
        end
    endtask

    task automatic test_errors();
        bit          wes  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [2:0]  mops [5] = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b010};
        logic [31:0] adrs [5] = '{32'h101, 32'h102, 32'h100, 32'h100, 32'h0002_0000};
        logic [31:0] rd;
        logic er;
        int lat, en_d, we_d;
        for (int i = 0; i < 5; i++) begin
            do_req(wes[i], mops[i], adrs[i], 32'hFFFF_FFFF, rd, er, lat, en_d, we_d);
            n_vec++;
            if (rd !== 32'h0 || er !== 1'b1 || lat != 1 || en_d != 0) begin
                n_fail++;
                $display("FAIL error[%0d]: got data=%h err=%b lat=%0d en=%0d, need 0 1 1 0",
                         i, rd, er, lat, en_d);
            end
        end
        n_vec++;
        if (mem[15'h40] !== 32'h8878_CAFE) begin
            n_fail++;
            $display("FAIL error_mem: got %h, need 8878cafe", mem[15'h40]);
        end
    endtask

    task automatic test_back_to_back();
        int resp_i = 0, acc_i = 0, lat = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_memop = 3'b010;
        req_addr = 32'h100; req_wdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        @(posedge clk);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            req_we = 1'b0; req_wdata = 32'h0;
            if (rsp_valid) resp_i = i;
            if (req_ready) begin acc_i = i; break; end
        end
        n_vec++;
        if (resp_i != 2 || acc_i != 3) begin
            n_fail++;
            $display("FAIL b2b_accept: got resp@%0d accept@%0d, need resp@2 accept@3",
                     resp_i, acc_i);
        end
        @(posedge clk);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (rsp_valid) begin lat = i; break; end
        end
        req_valid = 1'b0;
        n_vec++;
        if (rsp_rdata !== 32'hDEAD_BEEF || rsp_err !== 1'b0 || lat != 3) begin
            n_fail++;
            $display("FAIL b2b_read: got data=%h err=%b lat=%0d, need deadbeef 0 3",
                     rsp_rdata, rsp_err, lat);
        end
    endtask

    task automatic test_rst_mid();
        int we0;
        we0 = we_cnt;
        // SB reset during WAIT
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_memop = 3'b000; req_addr = 32'h100;
        req_wdata = 32'h55;
        @(posedge clk);
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        n_vec++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_wait: got ready=%b valid=%b, need 1 0", req_ready, rsp_valid);
        end
        // SW reset while the write strobe is up
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_memop = 3'b010; req_addr = 32'h104;
        req_wdata = 32'h1111_2222;
        @(posedge clk);
        @(negedge clk); req_valid = 1'b0; rst = 1'b1;
        #1;
        n_vec++;
        if (ram_we !== 1'b0 || ram_en !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_async: got en=%b we=%b, need 0 0", ram_en, ram_we);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (we_cnt != we0 || mem[15'h40] !== 32'hDEAD_BEEF || mem[15'h41] === 32'h1111_2222) begin
            n_fail++;
            $display("FAIL rst_mem: got writes=%0d w40=%h w41=%h, need 0 deadbeef untouched",
                     we_cnt - we0, mem[15'h40], mem[15'h41]);
        end
    endtask

    task automatic test_random();
        logic [2:0]  mop_set [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd2, 3'd3};
        logic [31:0] rd, addr, wd, exp_rd;
        logic [14:0] idx;
        logic [2:0]  mop;
        logic er;
        bit we, exp_err;
        int lat, en_d, we_d, exp_lat, exp_en;
        for (int w = 0; w < 8; w++) begin
            ref_mem[15'h40 + 15'(w)] = $urandom;
            bd_write(15'h40 + 15'(w), ref_mem[15'h40 + 15'(w)]);
        end
        for (int n = 0; n < 200; n++) begin
            we   = 1'($urandom_range(0, 1));
            mop  = mop_set[$urandom_range(0, 7)];
            wd   = $urandom;
            addr = ($urandom_range(0, 9) == 0) ? ($urandom | 32'h0002_0000)
                                               : (32'h100 + $urandom_range(0, 31));
            idx  = addr[16:2];
            exp_err = m_err(we, mop, addr);
            exp_rd  = (exp_err || we) ? 32'h0 : m_load(ref_mem[idx], mop, addr);
            exp_lat = exp_err ? 1 : (!we ? 3 : (m_size(mop) == 4 ? 2 : 4));
            exp_en  = exp_err ? 0 : ((we && m_size(mop) < 4) ? 2 : 1);
            if (!exp_err && we) ref_mem[idx] = m_store(ref_mem[idx], wd, mop, addr);
            do_req(we, mop, addr, wd, rd, er, lat, en_d, we_d);
            n_vec++;
            if (rd !== exp_rd || er !== exp_err || lat != exp_lat || en_d != exp_en ||
                we_d != int'(!exp_err && we)) begin
                n_fail++;
                $display("FAIL rand[%0d] we=%b mop=%0d addr=%h: got %h/%b/%0d/%0d/%0d need %h/%b/%0d/%0d/%0d",
                         n, we, mop, addr, rd, er, lat, en_d, we_d,
                         exp_rd, exp_err, exp_lat, exp_en, int'(!exp_err && we));
            end
            if (!exp_err) begin
                n_vec++;
                if (mem[idx] !== ref_mem[idx]) begin
                    n_fail++;
                    $display("FAIL rand_mem[%0d] word %h: got %h need %h",
                             n, idx, mem[idx], ref_mem[idx]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_stores();
        test_errors();
        test_back_to_back();
        test_rst_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
